pulse_handshake_tx: RTL

//  Source-side (fast domain) end of the toggle-handshake pulse crossing.
//  - Turns each single-cycle event on pulse_in into one toggle of req_tgl_out.
//  - Waits for the destination's ack toggle to match before launching the next event.
//  - Queues events that arrive while a handshake is in flight.
//  - The slow-domain receiver that echoes req_tgl as ack_tgl is a separate block.

---
 rtl/pulse_sync_pkg.sv | 13 +
 rtl/sync_ff_chain.sv | 24 ++
 rtl/pulse_handshake_tx.sv | 99 +++++++++
 3 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared types for the toggle-handshake pulse crossing.
// The transmitter and the receiver both import these.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer for a level/toggle signal from another clock domain.
// The transmitter and the receiver both use it.
module sync_ff_chain
  import pulse_sync_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: every flop is assigned with <= so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Fast-domain source of the toggle-handshake pulse crossing: queues events and toggles req per event.
// Optional ack watchdog with a sticky error state is built when macro ACK_TIMEOUT_EN is defined.
module pulse_handshake_tx
  import pulse_sync_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             ack_tgl_in,
  output logic             req_tgl_out,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   ack_s;
  logic   launch;
  logic   match;
  logic   cnt_full;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_fast),
    .rst_n (rst_n),
    .d     (ack_tgl_in),
    .q     (ack_s)
  );

  assign launch   = (state == IDLE) && ((pending_cnt != '0) || pulse_in);
  assign match    = (state == WAIT) && (ack_s == req_tgl_out);
  assign cnt_full = (pending_cnt == CNT_MAX);
  assign busy     = (state != IDLE) || (pending_cnt != '0);

`ifdef ACK_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMR_W-1:0] timer;
  logic             timeout;

  assign timeout = (state == WAIT) && !match && (timer == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      err   <= 1'b0;
    end else begin
      if (launch)              timer <= '0;
      else if (state == WAIT)  timer <= timer + 1'b1;
      if (timeout)             err   <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_tgl_out <= 1'b0;
      pending_cnt <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done     <= match;
      overflow <= pulse_in && !launch && cnt_full;

      // A pulse launched in the same cycle it arrives never touches the queue.
      if (pulse_in && !launch && !cnt_full) pending_cnt <= pending_cnt + 1'b1;
      else if (!pulse_in && launch)         pending_cnt <= pending_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (launch) begin
            req_tgl_out <= ~req_tgl_out;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (match) state <= IDLE;
`ifdef ACK_TIMEOUT_EN
          else if (timeout) state <= ERR;
`endif
        end
`ifdef ACK_TIMEOUT_EN
        ERR:     state <= ERR;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
